// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Ports: clk, Reset, flush, in_valid/in_ready/in_data/in_ctrl, out_*, occupancy.
module pipe_stage_skid #(
  parameter int unsigned DATA_W     = 107,
  parameter int unsigned CTRL_W     = 8,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

  logic in_fire;
  logic out_fire;

  assign in_ready  = (state_q != FULL) && !flush;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign occupancy = state_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            // Head is stalled: park the new beat behind it.
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the skid can advance.
          if (out_fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      if (CLEAR_DATA) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed handshake steps, then a random
// valid/ready/flush run checked against a queue model.
module tb_pipe_stage_skid;

  localparam int DW = 107;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          Reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t q[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CLEAR_DATA(1'b1)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] r;
    beat_t b;
    bit pop;
    bit push;

    Reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    out_ready = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_data", out_data, 0);

    // fill, then reset while full
    in_valid = 1'b1;
    in_data = 5;
    in_ctrl = 3;
    tick();
    in_data = 6;
    tick();
    in_valid = 1'b0;
    #1;
    chk("fill_occ", occupancy, 2);
    chk("fill_ready", in_ready, 0);
    chk("fill_data", out_data, 5);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    chk("rstf_valid", out_valid, 0);
    chk("rstf_occ", occupancy, 0);
    chk("rstf_ctrl", out_ctrl, 0);
    chk("rstf_ready", in_ready, 1);

    // stream 1..8 with downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = DW'(i);
      in_ctrl = CW'(i);
      tick();
      chk("strm_data", out_data, i);
      chk("strm_occ", occupancy, 1);
      chk("strm_ctrl", out_ctrl, i);
    end
    in_valid = 1'b0;
    tick();
    chk("strm_end", out_valid, 0);

    // stall for 3 cycles mid-stream
    in_valid = 1'b1;
    in_data = 'h11;
    in_ctrl = 1;
    tick();
    chk("st0_data", out_data, 'h11);
    out_ready = 1'b0;
    in_data = 'h12;
    tick();
    chk("st1_occ", occupancy, 2);
    chk("st1_ready", in_ready, 0);
    chk("st1_data", out_data, 'h11);
    in_data = 'h13;
    tick();
    chk("st2_data", out_data, 'h11);
    tick();
    chk("st3_occ", occupancy, 2);
    chk("st3_data", out_data, 'h11);
    out_ready = 1'b1;
    tick();
    chk("st4_data", out_data, 'h12);
    chk("st4_occ", occupancy, 1);
    tick();
    chk("st5_data", out_data, 'h13);
    chk("st5_occ", occupancy, 1);
    in_valid = 1'b0;
    tick();
    chk("st6_valid", out_valid, 0);

    // flush while full with a live input beat
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 'h21;
    tick();
    in_data = 'h22;
    tick();
    chk("fl0_occ", occupancy, 2);
    flush = 1'b1;
    in_data = 'hAA;
    #1;
    chk("fl_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_data", out_data, 0);
    out_ready = 1'b1;
    tick();
    chk("fl_after", out_valid, 0);

    // ctrl FF beat, then bubble
    in_valid = 1'b1;
    in_data = 'h31;
    in_ctrl = 8'hFF;
    tick();
    chk("ctl_ff", out_ctrl, 8'hFF);
    in_valid = 1'b0;
    tick();
    chk("ctl_bub_v", out_valid, 0);
    chk("ctl_bub_c", out_ctrl, 0);

    // junk on idle input must not disturb a held beat
    in_valid = 1'b1;
    in_data = 'h41;
    in_ctrl = 8'h5A;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_data = '1;
    in_ctrl = '1;
    tick();
    tick();
    chk("junk_data", out_data, 'h41);
    chk("junk_ctrl", out_ctrl, 8'h5A);
    chk("junk_occ", occupancy, 1);

    // random run against a queue model
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      Reset = ($urandom_range(0, 255) == 0);
      flush = ($urandom_range(0, 31) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_data = r[DW-1:0];
      in_ctrl = CW'($urandom());
      #1;
      chk("rnd_occ", occupancy, q.size());
      chk("rnd_valid", out_valid, q.size() != 0);
      chk("rnd_ready", in_ready, (q.size() < 2) && !flush);
      if (q.size() != 0) begin
        chk("rnd_data", out_data, q[0].d);
        chk("rnd_ctrl", out_ctrl, q[0].c);
      end else begin
        chk("rnd_ctrl0", out_ctrl, 0);
      end
      pop = (q.size() != 0) && out_ready;
      push = in_valid && (q.size() < 2) && !flush;
      b.d = in_data;
      b.c = in_ctrl;
      if (Reset || flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(b);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
